// File: rtl/ntru_conv_mac_seq_pkg.sv
// Shared definitions for the NTRU cyclic-convolution MAC sequencer.
package ntru_conv_mac_seq_pkg;

  // Coefficient width, fixed by the 11-bit MAC unit (q = 2048).
  localparam int W = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_WAIT_A,
    S_MAC,
    S_DRAIN
  } state_t;

  // Increment an index modulo n, so that n-1 wraps exactly to 0 for any n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

  // (n - idx) mod n, used as the starting b index for a coefficient a_idx.
  function automatic int wrap_neg(input int idx, input int n);
    return (idx == 0) ? 0 : n - idx;
  endfunction

endpackage

// File: rtl/ntru_conv_mac_seq_au.sv
// Combinational 11-bit multiply-accumulate unit: out = num3 + num1*num2 mod 2^11.
module AU_COMP11x11 (
  input  logic [10:0] num1,
  input  logic [10:0] num2,
  input  logic [10:0] num3,
  output logic [10:0] out
);

  // Everything is evaluated at 11 bits, so carries beyond bit 10 are dropped.
  assign out = num3 + num1 * num2;

endmodule

// File: rtl/ntru_conv_mac_seq.sv
// Cyclic convolution c = a*b mod (x^N - 1, 2^11): loads b, streams a one
// coefficient at a time, performs one MAC per cycle, then streams c out.
module ntru_conv_mac_seq
  import ntru_conv_mac_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  output logic         c_valid,
  output logic [W-1:0] c_data,
  input  logic         c_ready,
  output logic         done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_bcnt, r_icnt, r_k, r_j, r_ocnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b   [N];
  logic [W-1:0]  r_acc [N];
  logic [W-1:0]  r_c_data;
  logic          r_c_valid, r_done;
  logic [W-1:0]  w_au_out;
  logic          w_b_fire, w_a_fire, w_c_fire;

  // Handshakes derived from state directly so ready outputs never loop back.
  assign w_b_fire = b_valid && (r_state == S_LOAD_B);
  assign w_a_fire = a_valid && (r_state == S_WAIT_A);
  assign w_c_fire = c_ready && r_c_valid && (r_state == S_DRAIN);

  assign c_valid = r_c_valid;
  assign c_data  = r_c_data;
  assign done    = r_done;

  AU_COMP11x11 u_au (
    .num1 (r_a),
    .num2 (r_b[r_j]),
    .num3 (r_acc[r_k]),
    .out  (w_au_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and per-state handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    b_ready     = 1'b0;
    a_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_ready = 1'b1;
        if (w_b_fire && r_bcnt == LAST) w_state_nxt = S_WAIT_A;
      end
      S_WAIT_A: begin
        a_ready = 1'b1;
        if (w_a_fire) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        if (r_k == LAST) w_state_nxt = (r_icnt == LAST) ? S_DRAIN : S_WAIT_A;
      end
      S_DRAIN: begin
        if (w_c_fire && r_ocnt == LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters, coefficient files and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt    <= '0;
      r_icnt    <= '0;
      r_k       <= '0;
      r_j       <= '0;
      r_ocnt    <= '0;
      r_a       <= '0;
      r_c_data  <= '0;
      r_c_valid <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_b[i]   <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bcnt <= '0;
            for (int i = 0; i < N; i++) r_acc[i] <= '0;
          end
        end
        S_LOAD_B: begin
          if (w_b_fire) begin
            r_b[r_bcnt] <= b_data;
            r_bcnt      <= IW'(wrap_inc(int'(r_bcnt), N));
            if (r_bcnt == LAST) r_icnt <= '0;
          end
        end
        S_WAIT_A: begin
          if (w_a_fire) begin
            r_a <= a_data;
            r_k <= '0;
            r_j <= IW'(wrap_neg(int'(r_icnt), N));
          end
        end
        S_MAC: begin
          r_acc[r_k] <= w_au_out;
          r_k        <= IW'(wrap_inc(int'(r_k), N));
          r_j        <= IW'(wrap_inc(int'(r_j), N));
          if (r_k == LAST) begin
            if (r_icnt == LAST) begin
              // acc[0] was finished N-1 cycles ago, so it is safe to present now.
              r_ocnt    <= '0;
              r_c_valid <= 1'b1;
              r_c_data  <= r_acc[0];
            end else begin
              r_icnt <= r_icnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_c_fire) begin
            if (r_ocnt == LAST) begin
              r_c_valid <= 1'b0;
              r_done    <= 1'b1;
              r_ocnt    <= '0;
            end else begin
              r_ocnt   <= r_ocnt + 1'b1;
              r_c_data <= r_acc[IW'(wrap_inc(int'(r_ocnt), N))];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ntru_conv_mac_seq.sv
// Self-checking bench for ntru_conv_mac_seq against a plain cyclic-convolution model.
module tb_ntru_conv_mac_seq;

  localparam int N = 16;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         b_valid = 1'b0;
  logic         a_valid = 1'b0;
  logic         c_ready = 1'b0;
  logic [W-1:0] b_data = '0;
  logic [W-1:0] a_data = '0;
  logic         busy, b_ready, a_ready, c_valid, done;
  logic [W-1:0] c_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [W-1:0] ta [N];
  logic [W-1:0] tbv [N];
  logic [W-1:0] exp_c [N];
  logic [W-1:0] got_c [N];

  ntru_conv_mac_seq #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .c_valid (c_valid),
    .c_data  (c_data),
    .c_ready (c_ready),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // c_k = sum_i a_i * b_((k - i) mod N), reduced mod 2048.
  task automatic model();
    for (int k = 0; k < N; k++) begin
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += int'(ta[i]) * int'(tbv[(k - i + N) % N]);
      exp_c[k] = W'(s % 2048);
    end
  endtask

  task automatic run_product(input int vprob, input int cprob, input bit chk_lat,
                             input bit inj_start, input int stall, input int rst_at,
                             input string tag);
    int bi, ai, oi, t0, lat, since_a;
    bit bf, af, cf, extra, done_seen, fin, stalled, stall_bad;
    logic [W-1:0] d0;
    bi = 0; ai = 0; oi = 0; t0 = -1; lat = -1; since_a = -1;
    bf = 0; af = 0; cf = 0; extra = 0; done_seen = 0; fin = 0; stalled = 0; stall_bad = 0;
    model();
    for (int k = 0; k < N; k++) got_c[k] = '0;
    @(negedge clk);
    start = 1'b1;
    for (int cy = 0; cy < 20000 && !fin; cy++) begin
      @(negedge clk);
      start = 1'b0;
      if (bf) bi++;
      if (af) begin ai++; since_a = 0; end
      else if (since_a >= 0) since_a++;
      if (cf) oi++;
      if (done_seen) begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s done_width: done=%b on cycle after pulse, want 0", tag, done);
        end
        fin = 1;
      end else begin
        if (done === 1'b1) begin
          done_seen = 1;
          lat = cyc - t0;
        end
        if (bi >= N && b_ready) extra = 1;
        if (ai >= N && a_ready) extra = 1;
        if (oi >= N && c_valid) extra = 1;
        if (rst_at > 0 && ai == 1 && since_a == rst_at - 1) begin
          #1 rst_n = 1'b0;
          #1;
          n_cmp++;
          if ({busy, b_ready, a_ready, c_valid, done} !== 5'b0 || c_data !== '0) begin
            n_bad++;
            $display("FAIL %s async_reset: busy/br/ar/cv/done=%b c_data=%0d, want 00000 and 0",
                     tag, {busy, b_ready, a_ready, c_valid, done}, c_data);
          end
          b_valid = 1'b0;
          a_valid = 1'b0;
          c_ready = 1'b0;
          return;
        end
        if (inj_start && ai == 3 && since_a == 4) start = 1'b1;
        if (stall > 0 && !stalled && c_valid && oi == 2) begin
          c_ready = 1'b0;
          d0 = c_data;
          for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (c_valid !== 1'b1 || c_data !== d0) stall_bad = 1;
          end
          stalled = 1;
          n_cmp++;
          if (stall_bad || d0 !== exp_c[2]) begin
            n_bad++;
            $display("FAIL %s stall_hold: c_valid=%b c_data=%0d first=%0d, want 1 and %0d",
                     tag, c_valid, c_data, d0, exp_c[2]);
          end
        end
        if (!(b_valid && !bf)) b_valid = (bi < N) && ($urandom_range(99) < vprob);
        b_data = b_valid ? tbv[bi] : W'($urandom);
        if (!(a_valid && !af)) a_valid = (ai < N) && ($urandom_range(99) < vprob);
        a_data = a_valid ? ta[ai] : W'($urandom);
        c_ready = ($urandom_range(99) < cprob);
        bf = b_valid && b_ready;
        if (bf && t0 < 0) t0 = cyc;
        af = a_valid && a_ready;
        cf = c_valid && c_ready;
        if (cf) begin
          if (oi < N) got_c[oi] = c_data;
          else extra = 1;
        end
      end
    end
    b_valid = 1'b0;
    a_valid = 1'b0;
    c_ready = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL %s timeout: done not seen (b=%0d a=%0d c=%0d), want done", tag, bi, ai, oi);
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (got_c[k] !== exp_c[k]) begin
        n_bad++;
        $display("FAIL %s c[%0d]: got %0d want %0d", tag, k, got_c[k], exp_c[k]);
      end
    end
    n_cmp++;
    if (extra || oi != N) begin
      n_bad++;
      $display("FAIL %s handshake: extra=%0d c_count=%0d, want 0 and %0d", tag, extra, oi, N);
    end
    if (chk_lat) begin
      n_cmp++;
      if (lat != N + N * (N + 1) + N) begin
        n_bad++;
        $display("FAIL %s latency: got %0d cycles want %0d", tag, lat, N + N * (N + 1) + N);
      end
    end
  endtask

  task automatic set_identity();
    for (int k = 0; k < N; k++) begin
      ta[k]  = (k == 0) ? W'(1) : W'(0);
      tbv[k] = W'(k + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({busy, b_ready, a_ready, c_valid, done} !== 5'b0 || c_data !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy/br/ar/cv/done=%b c_data=%0d, want 00000 and 0",
               {busy, b_ready, a_ready, c_valid, done}, c_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || b_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b b_ready=%b, want 0 0", busy, b_ready);
    end
  endtask

  task automatic test_identity();
    set_identity();
    run_product(100, 100, 1, 0, 0, 0, "identity");
  endtask

  task automatic test_rotation();
    for (int k = 0; k < N; k++) begin
      ta[k]  = (k == 1) ? W'(1) : W'(0);
      tbv[k] = W'(k + 1);
    end
    run_product(100, 100, 1, 0, 0, 0, "rotation");
    n_cmp++;
    if (got_c[0] !== W'(16)) begin
      n_bad++;
      $display("FAIL rotation_wrap: c[0]=%0d want 16", got_c[0]);
    end
  endtask

  task automatic test_mod_wrap();
    for (int k = 0; k < N; k++) begin ta[k] = '0; tbv[k] = '0; end
    ta[0] = W'(2047);
    tbv[0] = W'(2047);
    run_product(100, 100, 0, 0, 0, 0, "wrap_2047");
    n_cmp++;
    if (got_c[0] !== W'(1)) begin
      n_bad++;
      $display("FAIL wrap_2047_c0: c[0]=%0d want 1", got_c[0]);
    end
    ta[0] = W'(1024);
    tbv[0] = W'(2);
    run_product(100, 100, 0, 0, 0, 0, "wrap_1024");
    n_cmp++;
    if (got_c[0] !== W'(0)) begin
      n_bad++;
      $display("FAIL wrap_1024_c0: c[0]=%0d want 0", got_c[0]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 50; r++) begin
      for (int k = 0; k < N; k++) begin
        ta[k]  = W'($urandom);
        tbv[k] = W'($urandom);
      end
      run_product(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0, 0, 0, 0,
                  $sformatf("random%0d", r));
    end
  endtask

  task automatic test_control_edges();
    for (int k = 0; k < N; k++) begin
      ta[k]  = W'($urandom);
      tbv[k] = W'($urandom);
    end
    run_product(100, 100, 0, 1, 100, 0, "ctrl_edges");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < N; k++) begin
      ta[k]  = W'($urandom);
      tbv[k] = W'($urandom);
    end
    run_product(100, 100, 0, 0, 0, 7, "reset_mid");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (c_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_hold: c_valid=%b busy=%b, want 0 0", c_valid, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    set_identity();
    run_product(100, 100, 1, 0, 0, 0, "post_reset_identity");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotation();
    test_mod_wrap();
    test_random();
    test_control_edges();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
